// File: rtl/mp_addsub_sequencer_if.sv
// Request/response bundle for mp_addsub_sequencer: operand handshake in, result handshake out.
// master drives requests and accepts results; slave is the sequencer side.
interface mp_addsub_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/mp_addsub_sequencer.sv
// Multi-precision add/subtract sequencer: one 16-bit Kogge-Stone adder reused over WORDS slices, LSW first.
// Optional macro MPADD_SAT_EN saturates the result to the signed extreme on overflow.
module kogge_stone_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] gl [5];
  logic [15:0] pl [5];

  // Cin is folded into bit 0's generate so the prefix tree yields carry-into-bit directly.
  always_comb begin
    gl[0] = a & b;
    pl[0] = a ^ b;
    gl[0][0] = gl[0][0] | (pl[0][0] & cin);
    for (int lvl = 0; lvl < 4; lvl++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << lvl)) begin
          gl[lvl+1][i] = gl[lvl][i] | (pl[lvl][i] & gl[lvl][i - (1 << lvl)]);
          pl[lvl+1][i] = pl[lvl][i] & pl[lvl][i - (1 << lvl)];
        end else begin
          gl[lvl+1][i] = gl[lvl][i];
          pl[lvl+1][i] = pl[lvl][i];
        end
      end
    end
    sum  = pl[0] ^ {gl[4][14:0], cin};
    cout = gl[4][15];
  end
endmodule

module mp_addsub_sequencer #(
  parameter int WORDS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mp_addsub_sequencer_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_reg, b_reg, sum_reg;
  logic           sub_reg, carry, cout_reg, ovf_reg;
  logic [IW-1:0]  idx;
  logic [15:0]    a_slice, b_slice, s_slice;
  logic           c_slice, ovf_slice, last_slice;

  always_comb begin
    a_slice    = a_reg[16*idx +: 16];
    b_slice    = b_reg[16*idx +: 16] ^ {16{sub_reg}};
    ovf_slice  = (a_slice[15] == b_slice[15]) && (s_slice[15] != a_slice[15]);
    last_slice = (idx == IW'(WORDS - 1));
  end

  kogge_stone_adder_16 u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry),
    .sum  (s_slice),
    .cout (c_slice)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry register starts at sub so subtraction is A + ~B + 1 across the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            sub_reg <= bus.sub;
            carry   <= bus.sub;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_reg[16*idx +: 16] <= s_slice;
          carry <= c_slice;
          idx   <= idx + 1'b1;
          if (last_slice) begin
            cout_reg <= c_slice;
            ovf_reg  <= ovf_slice;
`ifdef MPADD_SAT_EN
            if (ovf_slice)
              sum_reg <= a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.sum  = sum_reg;
    bus.cout = cout_reg;
    bus.ovf  = ovf_reg;
  end
endmodule
